mem_bus_responder: RTL and testbench

- Target end of the byte-wide memory bus driven by the CPU memory controller.
- Decodes each bus cycle to RAM or memory-mapped IO.
- Returns read data with a fixed 1-cycle latency.
- Buffers IO output bytes in a TX FIFO, reports back-pressure on io_buffer_full, and raises program_end on a halt write.
- Sits at top level between the CPU core, block RAM and the UART/host link.

---
 rtl/mem_bus_responder_pkg.sv | 31 +++
 rtl/mem_bus_responder_byte_fifo.sv | 63 ++++++
 rtl/mem_bus_responder.sv | 124 ++++++++++++
 tb/tb_mem_bus_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory bus responder: byte type, IO map and decode.
// Latency: none (types, constants and a combinational decode helper only).
// Backpressure: not applicable.
package mem_bus_responder_pkg;

  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;

  // IO map: bits [17:16] == 2'b11 select IO, everything else is RAM.
  localparam logic [31:0] IO_BASE    = 32'h0003_0000;
  localparam logic [31:0] IO_HALT    = 32'h0003_0004;
  localparam int          IO_SEL_HI  = 17;
  localparam int          IO_SEL_LO  = 16;
  localparam logic [1:0]  IO_SEL_VAL = 2'b11;

  typedef enum logic [1:0] {
    ACC_RAM     = 2'd0,
    ACC_IO_DATA = 2'd1,
    ACC_IO_HALT = 2'd2,
    ACC_IO_NONE = 2'd3
  } acc_e;

  // Classify a bus address; bits above the IO select field never matter.
  function automatic acc_e decode_acc(input logic [IO_SEL_HI:0] addr);
    if (addr[IO_SEL_HI:IO_SEL_LO] != IO_SEL_VAL) return ACC_RAM;
    if (addr == IO_BASE[IO_SEL_HI:0])            return ACC_IO_DATA;
    if (addr == IO_HALT[IO_SEL_HI:0])            return ACC_IO_HALT;
    return ACC_IO_NONE;
  endfunction

endpackage

// File: rtl/mem_bus_responder_byte_fifo.sv
// Small byte FIFO with occupancy count; head is shown combinationally.
// Latency: a pushed byte is visible at the head the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens the same cycle; pop ignored when empty.
module byte_fifo
  import mem_bus_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  byte_t                    push_data_i,
  input  logic                     pop_i,
  output byte_t                    head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO may proceed alongside it.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Control registers, flushed by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Bus target: decodes RAM vs IO, returns read data, buffers TX bytes, tracks halt/overflow.
// Latency: read data registered, valid one cycle after the address; rx_ack in the read cycle.
// Backpressure: io_buffer_full (registered) warns the initiator early; pushes into a full FIFO are dropped and flagged.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH  = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mc_to_mem_addr,
  input  logic [7:0]  mc_to_mem_dout,
  input  logic        mc_to_mem_wr,
  output logic [7:0]  mem_to_mc_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ack,
  output logic        program_end,
  output logic        tx_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  byte_t                 ram [2**ADDR_WIDTH];
  byte_t                 ram_rd_dat;
  logic [ADDR_WIDTH-1:0] ram_addr;
  acc_e                  acc;

  byte_t                 din_q, din_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  halt_q, halt_d;

  logic                  fifo_push, fifo_pop;
  logic                  fifo_push_ok, fifo_pop_ok;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count, next_count;
  byte_t                 fifo_head;

  // Address bits above the IO select field are don't-care on this bus.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mc_to_mem_addr[31:IO_SEL_HI+1];

  assign acc        = decode_acc(mc_to_mem_addr[IO_SEL_HI:0]);
  assign ram_addr   = mc_to_mem_addr[ADDR_WIDTH-1:0];
  assign ram_rd_dat = ram[ram_addr];

  assign fifo_push    = rdy_in && mc_to_mem_wr && (acc == ACC_IO_DATA);
  assign fifo_pop     = rdy_in && tx_ready;
  assign fifo_pop_ok  = fifo_pop && !fifo_empty;
  assign fifo_push_ok = fifo_push && (!fifo_full || fifo_pop_ok);
  assign next_count   = fifo_count + CW'(fifo_push_ok) - CW'(fifo_pop_ok);

  // The host byte is consumed in the same cycle the initiator reads the RX address.
  assign rx_ack = !rst_in && rdy_in && !mc_to_mem_wr && (acc == ACC_IO_DATA) && rx_valid;

  assign mem_to_mc_din  = din_q;
  assign io_buffer_full = full_q;
  assign program_end    = halt_q;
  assign tx_overflow    = ovf_q;
  assign tx_valid       = !fifo_empty;
  assign tx_data        = fifo_head;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .push_i      (fifo_push),
    .push_data_i (mc_to_mem_dout),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // RAM write port; array contents are never reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && mc_to_mem_wr && (acc == ACC_RAM)) ram[ram_addr] <= mc_to_mem_dout;
  end

  // Read-data mux and sticky flags; everything holds while rdy_in is low.
  always_comb begin
    din_d  = din_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    halt_d = halt_q;
    if (rdy_in) begin
      if (!mc_to_mem_wr) begin
        case (acc)
          ACC_RAM:     din_d = ram_rd_dat;
          ACC_IO_DATA: din_d = rx_valid ? rx_data : '0;
          default:     din_d = '0;
        endcase
      end
      if (mc_to_mem_wr && (acc == ACC_IO_HALT)) halt_d = 1'b1;
      if (fifo_push && fifo_full && !fifo_pop_ok) ovf_d = 1'b1;
      // Threshold leaves FULL_MARGIN slots for bytes issued before the initiator sees the flag.
      full_d = (next_count >= CW'(FIFO_DEPTH - FULL_MARGIN));
    end
  end

  // Output and flag registers with synchronous reset taking priority over rdy_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      din_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      din_q  <= din_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      halt_q <= halt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: vector table plus hand-written multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A small model tracks the TX FIFO and flags; read data expectations are explicit constants.
module tb_mem_bus_responder;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [31:0] addr;
  logic [7:0]  dout;
  logic        wr;
  logic [7:0]  mem_to_mc_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        program_end;
  logic        tx_overflow;

  always #5 clk_in = ~clk_in;

  mem_bus_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mc_to_mem_addr (addr),
    .mc_to_mem_dout (dout),
    .mc_to_mem_wr   (wr),
    .mem_to_mc_din  (mem_to_mc_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ack         (rx_ack),
    .program_end    (program_end),
    .tx_overflow    (tx_overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] rd_q [$];
  logic [7:0] tx_m [$];
  logic       halt_m = 1'b0;
  logic       ovf_m  = 1'b0;
  logic       full_m = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  dout;
    logic        rxv;
    logic [7:0]  rxd;
    logic [7:0]  exp_din;
    logic        exp_ack;
  } vec_t;

  vec_t tbl [12];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // One bus cycle: check registered results of the previous edge and this cycle's
  // combinational outputs, queue the read expectation, then advance the model past the edge.
  task automatic step(input logic rd_chk, input logic [7:0] exp_rd, input logic exp_ack);
    logic       pop_m;
    logic [7:0] e;
    @(negedge clk_in);
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk8("rd_data", mem_to_mc_din, e);
    end
    chk1("rx_ack", rx_ack, exp_ack);
    chk1("tx_valid", tx_valid, tx_m.size() > 0);
    chk1("io_buffer_full", io_buffer_full, full_m);
    chk1("tx_overflow", tx_overflow, ovf_m);
    chk1("program_end", program_end, halt_m);
    pop_m = !rst_in && rdy_in && tx_ready && (tx_m.size() > 0);
    if (pop_m) chk8("tx_data", tx_data, tx_m[0]);
    if (rd_chk) rd_q.push_back(exp_rd);
    if (rst_in) begin
      tx_m.delete();
      halt_m = 1'b0;
      ovf_m  = 1'b0;
      full_m = 1'b0;
    end else if (rdy_in) begin
      if (pop_m) e = tx_m.pop_front();
      if (wr && addr[17:0] == 18'h30000) begin
        if (tx_m.size() < 8) tx_m.push_back(dout);
        else ovf_m = 1'b1;
      end
      if (wr && addr[17:0] == 18'h30004) halt_m = 1'b1;
      full_m = (tx_m.size() >= 6);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d,
                     input logic rc, input logic [7:0] er);
    addr = a;
    wr   = w;
    dout = d;
    step(rc, er, 1'b0);
  endtask

  // Write to an unmapped IO address: no side effect, read data holds.
  task automatic idle();
    bus(32'h0003_0008, 1'b1, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    addr     = 32'h0003_0008;
    wr       = 1'b1;
    dout     = 8'h00;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // Reset state
    chk8("reset_din", mem_to_mc_din, 8'h00);
    chk1("reset_full", io_buffer_full, 1'b0);
    chk1("reset_rx_ack", rx_ack, 1'b0);
    chk1("reset_program_end", program_end, 1'b0);
    chk1("reset_overflow", tx_overflow, 1'b0);
    chk1("reset_tx_valid", tx_valid, 1'b0);

    // Vector table: exp_din is the value mem_to_mc_din must show in the following cycle.
    tbl[0]  = '{32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0};
    tbl[2]  = '{32'h0000_0011, 1'b1, 8'h3C, 1'b0, 8'h00, 8'hA5, 1'b0};
    tbl[3]  = '{32'h0000_0011, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0};
    tbl[4]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h37, 8'h37, 1'b1};
    tbl[5]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h37, 8'h00, 1'b0};
    tbl[6]  = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h55, 8'h00, 1'b0};
    tbl[7]  = '{32'h1234_0012, 1'b1, 8'h77, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{32'h0000_0012, 1'b0, 8'h00, 1'b0, 8'h00, 8'h77, 1'b0};
    tbl[9]  = '{32'hABC0_0011, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0};
    tbl[10] = '{32'h0003_0008, 1'b1, 8'h99, 1'b0, 8'h00, 8'h3C, 1'b0};
    tbl[11] = '{32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0};
    for (int i = 0; i < 12; i++) begin
      addr     = tbl[i].addr;
      wr       = tbl[i].wr;
      dout     = tbl[i].dout;
      rx_valid = tbl[i].rxv;
      rx_data  = tbl[i].rxd;
      step(1'b1, tbl[i].exp_din, tbl[i].exp_ack);
    end
    rx_valid = 1'b0;

    // TX basics: two non-adjacent pushes, head is the first byte, then drain in order.
    bus(32'h0003_0000, 1'b1, 8'h48, 1'b0, 8'h00);
    idle();
    bus(32'h0003_0000, 1'b1, 8'h69, 1'b0, 8'h00);
    idle();
    chk8("tx_head_H", tx_data, 8'h48);
    tx_ready = 1'b1;
    idle();
    idle();
    tx_ready = 1'b0;
    idle();
    chk1("tx_drained", tx_valid, 1'b0);

    // Fill to threshold, overflow, then simultaneous push+pop while full.
    for (int i = 0; i < 6; i++) begin
      bus(32'h0003_0000, 1'b1, 8'(i), 1'b0, 8'h00);
      if (i == 4) chk1("full_below_thr", io_buffer_full, 1'b0);
    end
    chk1("full_at_thr", io_buffer_full, 1'b1);
    bus(32'h0003_0000, 1'b1, 8'h06, 1'b0, 8'h00);
    bus(32'h0003_0000, 1'b1, 8'h07, 1'b0, 8'h00);
    chk1("no_ovf_at_8", tx_overflow, 1'b0);
    bus(32'h0003_0000, 1'b1, 8'h08, 1'b0, 8'h00);
    chk1("ovf_on_9th", tx_overflow, 1'b1);
    tx_ready = 1'b1;
    bus(32'h0003_0000, 1'b1, 8'hEE, 1'b0, 8'h00);
    chk1("full_after_pushpop", io_buffer_full, 1'b1);
    repeat (8) idle();
    // Push while empty with tx_ready high: no pop that cycle, byte lands.
    bus(32'h0003_0000, 1'b1, 8'h42, 1'b0, 8'h00);
    chk8("empty_pushpop_head", tx_data, 8'h42);
    idle();
    tx_ready = 1'b0;
    idle();
    chk1("full_cleared", io_buffer_full, 1'b0);

    // Halt flag is sticky across traffic; reset clears flags and FIFO but not RAM.
    bus(32'h0003_0004, 1'b1, 8'hFF, 1'b0, 8'h00);
    chk1("halt_set", program_end, 1'b1);
    bus(32'h0003_0000, 1'b1, 8'h55, 1'b0, 8'h00);
    bus(32'h0000_0011, 1'b0, 8'h00, 1'b1, 8'h3C);
    idle();
    chk1("halt_held", program_end, 1'b1);
    bus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
    rst_in = 1'b1;
    bus(32'h0000_0011, 1'b0, 8'h00, 1'b1, 8'h00);
    rst_in = 1'b0;
    chk1("rst_halt", program_end, 1'b0);
    chk1("rst_ovf", tx_overflow, 1'b0);
    chk1("rst_full", io_buffer_full, 1'b0);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk8("rst_din", mem_to_mc_din, 8'h00);
    bus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);

    // rdy_in low: no RAM write, no push, no pop, read data holds.
    bus(32'h0000_0020, 1'b1, 8'h11, 1'b1, 8'hA5);
    bus(32'h0003_0000, 1'b1, 8'h61, 1'b1, 8'hA5);
    bus(32'h0000_0020, 1'b0, 8'h00, 1'b1, 8'h11);
    rdy_in   = 1'b0;
    tx_ready = 1'b1;
    bus(32'h0000_0020, 1'b1, 8'h5A, 1'b1, 8'h11);
    bus(32'h0003_0000, 1'b1, 8'h62, 1'b1, 8'h11);
    bus(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h11);
    chk8("hold_head", tx_data, 8'h61);
    chk1("hold_tx_valid", tx_valid, 1'b1);
    rdy_in = 1'b1;
    bus(32'h0000_0020, 1'b0, 8'h00, 1'b1, 8'h11);
    tx_ready = 1'b0;
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
